// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse meter: FSM state encoding and default counter width.
package pulse_meter_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pulse_meter_if.sv
// Result handshake bundle: the meter drives result/overflow/result_valid, the consumer drives result_ready.
interface pulse_meter_if
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output result,
        output overflow,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  result,
        input  overflow,
        input  result_valid,
        output result_ready
    );

endinterface

// File: rtl/pulse_meter_satcnt.sv
// Saturating up-counter: load starts at 1, inc counts until all-ones, a further inc sets ovf.
module pulse_meter_satcnt
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] cnt_q;
    logic             ovf_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= {{(WIDTH-1){1'b0}}, 1'b1};
            ovf_q <= 1'b0;
        end else if (inc_i) begin
            // At all-ones the count holds; ovf marks that the pulse outlived the range.
            if (cnt_q == {WIDTH{1'b1}}) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures the high time of sig_in in clk cycles and hands the result over a valid/ready bundle.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          sig_in,
    output logic          measuring,
    pulse_meter_if.master res
);

    state_e           state_q, state_d;
    logic             sig_prev_q;
    logic             rise;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;

    logic             cnt_load, cnt_inc, cnt_clr;
    logic [WIDTH-1:0] cnt;
    logic             cnt_ovf;

    // sig_prev resets high so a level already present is never taken as an edge.
    assign rise = sig_in & ~sig_prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sig_prev_q <= 1'b1;
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_prev_q <= sig_in;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (rise) begin
                    state_d  = ST_COUNT;
                    cnt_load = 1'b1;
                end
            end
            ST_COUNT: begin
                // Abort wins over a falling edge in the same cycle.
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (!sig_in) begin
                    state_d    = ST_DONE;
                    result_d   = cnt;
                    overflow_d = cnt_ovf;
                    valid_d    = 1'b1;
                    cnt_clr    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                if (valid_q && res.result_ready) begin
                    valid_d = 1'b0;
                    state_d = enable ? ST_ARMED : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    pulse_meter_satcnt #(.WIDTH(WIDTH)) u_satcnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .load_i (cnt_load),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .cnt_o  (cnt),
        .ovf_o  (cnt_ovf)
    );

    assign res.result       = result_q;
    assign res.overflow     = overflow_q;
    assign res.result_valid = valid_q;
    assign measuring        = (state_q == ST_COUNT);

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the width of the counter and the result.
REQ-002 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port enable, input, 1 bit: arms the meter while high.
REQ-005 The block SHALL have port sig_in, input, 1 bit: the pulse to be measured (a busy-style level), synchronous to clk.
REQ-006 The block SHALL have port result, output, WIDTH bits: the measured high time in clk cycles.
REQ-007 The block SHALL have port overflow, output, 1 bit: high when the measured pulse exceeded 2^WIDTH-1 cycles; qualified by result_valid.
REQ-008 The block SHALL have port result_valid, output, 1 bit: result and overflow are held and valid.
REQ-009 The block SHALL have port result_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port measuring, output, 1 bit: a pulse is currently being counted.

Function
REQ-011 The block SHALL implement four states: IDLE, ARMED, COUNT and DONE.
REQ-012 The block SHALL register sig_in into sig_prev every cycle; rise = sig_in & !sig_prev.
REQ-013 In IDLE, enable=1 SHALL move the FSM to ARMED on the next cycle, and all other inputs are ignored.
REQ-014 In ARMED:
- enable=0 SHALL move the FSM to IDLE; enable has priority over rise in the same cycle.
- Otherwise, rise=1 SHALL move the FSM to COUNT and load counter=1.
REQ-015 In COUNT:
- While sig_in=1 and enable=1, counter SHALL increment by 1 per cycle.
- At 2^WIDTH-1 the counter SHALL saturate (hold) and set an internal ovf flag.
REQ-016 In COUNT, the first cycle with sig_in=0 SHALL:
- capture result<=counter and overflow<=ovf;
- assert result_valid from the next cycle;
- move the FSM to DONE.
A pulse high for N clock samples therefore reports result=N, with latency of one cycle after the falling sample.
REQ-017 In COUNT, enable=0 SHALL abort to IDLE with no result, and counter and ovf are cleared. Abort has priority over a simultaneous falling edge.
REQ-018 In DONE:
- result_valid SHALL stay 1, and result/overflow SHALL stay stable, until result_valid & result_ready.
- On that handshake the FSM SHALL move to ARMED if enable=1, else to IDLE.
- result_valid SHALL drop on the following cycle.
REQ-019 In DONE, enable=0 SHALL NOT discard a pending result; the FSM exits only via the handshake.
REQ-020 Rising edges of sig_in seen in any state other than ARMED (including the handshake cycle) SHALL be ignored, and no count is carried over.
REQ-021 result_ready while result_valid=0 SHALL have no effect.
REQ-022 measuring SHALL be 1 exactly while the FSM is in COUNT.
REQ-023 A level already high when the FSM enters ARMED SHALL NOT be measured; only a subsequent 0->1 edge starts a count.

Reset
REQ-024 When reset=0 at a clk edge, the block SHALL:
- set the FSM to IDLE;
- clear counter, ovf, result, overflow, result_valid and measuring to 0;
- set sig_prev to 1.
REQ-025 Reset asserted mid-COUNT or mid-DONE SHALL discard all progress, and no result_valid pulse appears.
REQ-026 The outputs SHALL be valid (at reset values) on the first cycle after reset.

Structure
REQ-027 A shared package pulse_meter_pkg SHALL hold the FSM state enumeration and the default WIDTH constant.
REQ-028 The saturating counter and its ovf flag SHALL be one sub-module, pulse_meter_satcnt, with inputs load, inc and clr.
REQ-029 The block SHALL contain no combinational path from sig_in to any output.

Verification
REQ-030 Bench with the team timer driving sig_in from busy, enable=1, timer loaded with cycles=7 -> result_valid=1 with result=7 and overflow=0.
REQ-031 Single-cycle pulse on sig_in -> result=1, and result_valid asserts 2 cycles after the rising sample.
REQ-032 WIDTH=4 with sig_in high for 20 cycles -> result=15, overflow=1.
REQ-033 sig_in already high when enable rises, then falls, then rises and stays high 3 cycles -> exactly one result, result=3.
REQ-034 result_ready held low 10 cycles after valid, with a second pulse arriving meanwhile -> result held constant; the second pulse is ignored; after the handshake, the FSM is ARMED with no result_valid.
REQ-035 enable dropped at count 4 mid-pulse, and separately reset=0 mid-count -> FSM in IDLE, no result_valid, measuring=0 on the next cycle.
